// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the MEM-stage data-RAM arbiter.
// It carries the CPU port, the DMA/debug port and the single-port RAM side.
// Handshake on each requester port:
//   req is raised with we/addr/wdata stable, and all of them are held until gnt=1.
//   The transfer completes at the clk edge where req&gnt=1.
//   gnt is combinational from req and the arbiter state.
//   At most one gnt is high per cycle.
//   A granted read returns rvalid for one cycle, one cycle later.
// The "slave" modport is the arbiter side.
// The "master" modport is the requester and RAM side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_err;

  logic              dma_req;
  logic              dma_we;
  logic [31:0]       dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_gnt;
  logic [31:0]       dma_rdata;
  logic              dma_rvalid;
  logic              dma_err;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  logic              dma_starved;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid, dma_err,
    output ram_we, ram_addr, ram_din,
    input  ram_dout,
    output dma_starved
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid, dma_err,
    input  ram_we, ram_addr, ram_din,
    output ram_dout,
    input  dma_starved
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data RAM of the MEM stage.
// The CPU has fixed priority.
// After MAX_WAIT consecutive blocked cycles the DMA/debug port gets one forced slot.
// Read data is routed back to the owner of each access by a registered tag.
// Optional build macro DMEM_ALIGN_CHECK_EN enables misaligned-access detection:
//   a misaligned access is consumed without writing the RAM,
//   and it raises err one cycle after the grant.
// dbgState (1 = PRI_DMA) and dbgWaitCnt expose the arbitration state for checkers.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_arbiter_if.slave    bus,
  output logic             dbgState,
  output logic [CNT_W-1:0] dbgWaitCnt
);

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_DMA = 1'b1
  } arbStateT;

  localparam logic [CNT_W-1:0] WaitMax  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MAX_WAIT - 1);

  arbStateT         state;
  arbStateT         stateNext;
  logic [CNT_W-1:0] waitCnt;

  logic             cpuGnt;
  logic             dmaGnt;
  logic             anyGnt;

  logic             selWe;
  logic [31:0]      selAddr;
  logic [31:0]      selWdata;
  logic             selMis;

  // Return tag captured on every grant, consumed the following cycle.
  logic             rdPend;
  logic             accOwner;   // 0 = CPU, 1 = DMA
  logic             misPend;

  logic             cpuRvalid;
  logic             dmaRvalid;
  logic [31:0]      retData;
  logic [31:0]      cpuRdataQ;
  logic [31:0]      dmaRdataQ;

  logic             unusedAddrBits;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PRI_CPU;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state: force one DMA slot after MAX_WAIT blocked cycles; give priority back after it.
  always_comb begin
    stateNext = state;
    case (state)
      PRI_CPU: begin
        if (bus.dma_req && !dmaGnt && (waitCnt >= WaitLast)) begin
          stateNext = PRI_DMA;
        end
      end
      PRI_DMA: begin
        // A dropped request in PRI_DMA violates the handshake.
        // It is tolerated by simply giving priority back to the CPU.
        if (dmaGnt || !bus.dma_req) begin
          stateNext = PRI_CPU;
        end
      end
      default: stateNext = PRI_CPU;
    endcase
  end

  // FSM outputs: the grants follow the current priority.
  // Grants are held off while reset is asserted.
  always_comb begin
    cpuGnt = 1'b0;
    dmaGnt = 1'b0;
    if (reset_n) begin
      case (state)
        PRI_CPU: begin
          cpuGnt = bus.cpu_req;
          dmaGnt = bus.dma_req && !bus.cpu_req;
        end
        PRI_DMA: begin
          dmaGnt = bus.dma_req;
          cpuGnt = bus.cpu_req && !bus.dma_req;
        end
        default: begin
          cpuGnt = 1'b0;
          dmaGnt = 1'b0;
        end
      endcase
    end
  end

  assign anyGnt          = cpuGnt || dmaGnt;
  assign bus.cpu_gnt     = cpuGnt;
  assign bus.dma_gnt     = dmaGnt;
  assign bus.dma_starved = (state == PRI_DMA);
  assign dbgState        = (state == PRI_DMA);
  assign dbgWaitCnt      = waitCnt;

  // Starvation counter: counts consecutive blocked DMA cycles and saturates at MAX_WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waitCnt <= '0;
    end else if (!bus.dma_req || dmaGnt) begin
      waitCnt <= '0;
    end else if (waitCnt < WaitMax) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // Select the winning port's command; drive zeros when nobody is granted.
  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    if (cpuGnt) begin
      selWe    = bus.cpu_we;
      selAddr  = bus.cpu_addr;
      selWdata = bus.cpu_wdata;
    end else if (dmaGnt) begin
      selWe    = bus.dma_we;
      selAddr  = bus.dma_addr;
      selWdata = bus.dma_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign selMis = anyGnt && (selAddr[1:0] != 2'b00);
`else
  assign selMis = 1'b0;
`endif

  // Byte-lane and high address bits carry no meaning for the word-wide RAM.
  assign unusedAddrBits = ^{selAddr[31:ADDR_W+2], selAddr[1:0]};

  assign bus.ram_we   = anyGnt && selWe && !selMis;
  assign bus.ram_addr = selAddr[ADDR_W+1:2];
  assign bus.ram_din  = selWdata;

  // Register the owner tag, the read flag and the misalignment flag of the access granted this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPend   <= 1'b0;
      accOwner <= 1'b0;
      misPend  <= 1'b0;
    end else begin
      rdPend   <= anyGnt && !selWe;
      accOwner <= dmaGnt;
      misPend  <= selMis;
    end
  end

  assign cpuRvalid = rdPend && !accOwner;
  assign dmaRvalid = rdPend && accOwner;
  assign retData   = misPend ? 32'h0 : bus.ram_dout;

  // Per-port read data holding registers, loaded on that port's read return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpuRdataQ <= '0;
      dmaRdataQ <= '0;
    end else begin
      if (cpuRvalid) cpuRdataQ <= retData;
      if (dmaRvalid) dmaRdataQ <= retData;
    end
  end

  // The returning word is presented in the rvalid cycle itself.
  // Afterwards the holding register keeps it.
  assign bus.cpu_rvalid = cpuRvalid;
  assign bus.dma_rvalid = dmaRvalid;
  assign bus.cpu_rdata  = cpuRvalid ? retData : cpuRdataQ;
  assign bus.dma_rdata  = dmaRvalid ? retData : dmaRdataQ;

`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.cpu_err = misPend && !accOwner;
  assign bus.dma_err = misPend && accOwner;
`else
  assign bus.cpu_err = 1'b0;
  assign bus.dma_err = 1'b0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM of the MEM stage between two requesters.
- Port C is the CPU MEM stage; port D is the DMA/debug loader.
- CPU has fixed priority. A starvation counter guarantees DMA one access slot after MAX_WAIT blocked cycles.
- Drives the RAM word address, write enable and write data, and routes registered read data back to the owner of each access.

Parameters:
- ADDR_W, 10, RAM word-address width; the RAM address is addr[ADDR_W+1:2].
- MAX_WAIT, 4, number of consecutive blocked DMA cycles before DMA is forced priority; legal range is 1..255.
- CNT_W, 8, width of the starvation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rdata  out  32  CPU read data.
- cpu_rvalid  out  1  CPU read data valid (1-cycle pulse).
- cpu_err  out  1  CPU misaligned-access flag (see Optional Feature).
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rdata, dma_rvalid, dma_err: same as the cpu_* ports, for DMA.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid one cycle after the address.
- dma_starved  out  1  high while the FSM is in PRI_DMA.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values:
  - gnt, rvalid, err, ram_we, dma_starved are 0.
  - rdata regs are 0.
  - wait_cnt is 0.
  - FSM is in PRI_CPU.
  - Any pending read return is discarded.
- Handshake:
  - A requester asserts req with we/addr/wdata stable and holds them until gnt=1.
  - The transfer completes at the clk edge where req&gnt=1.
  - gnt is combinational from req and the FSM state.
  - At most one gnt per cycle.
- FSM:
  - PRI_CPU: cpu_gnt=cpu_req; dma_gnt=dma_req&!cpu_req.
  - PRI_DMA: dma_gnt=dma_req; cpu_gnt=cpu_req&!dma_req.
  - The CPU pipeline must stall while cpu_req&!cpu_gnt.
- Starvation counter:
  - wait_cnt increments on each cycle with dma_req&!dma_gnt.
  - wait_cnt clears to 0 on any dma_gnt, or when dma_req=0.
  - Saturates at MAX_WAIT.
- Transitions:
  - PRI_CPU -> PRI_DMA at the edge where wait_cnt==MAX_WAIT-1 and DMA is blocked again. DMA therefore wins the cycle after MAX_WAIT blocked cycles.
  - PRI_DMA -> PRI_CPU after one dma_gnt, or if dma_req drops (protocol violation; tolerated).
- RAM drive (combinational from the winning port):
  - ram_we=we&gnt; ram_addr=addr[ADDR_W+1:2]; ram_din=wdata.
  - With no grant: ram_we=0, ram_addr=0, ram_din=0.
  - addr[1:0] and addr[31:ADDR_W+2] are ignored (no range check).
- Read return:
  - A 1-bit owner tag plus a read flag are registered on a granted read.
  - Next cycle, the owning port's rvalid=1 for exactly one cycle and its rdata register loads ram_dout.
  - rdata holds until that port's next read return.
- Writes produce no rvalid.
- Back-to-back reads, including alternating owners, sustain one access per cycle; each return is routed by its own tag.
- Simultaneous requests with wait_cnt<MAX_WAIT-1: CPU wins, DMA counter increments.
- A read followed the next cycle by a write to the same word returns the old data; the write lands at the second edge.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A granted access with addr[1:0]!=0 is consumed (gnt=1) but ram_we is forced to 0.
  - A misaligned read still pulses rvalid next cycle, with rdata=0 and err=1 in the same cycle.
  - A misaligned write pulses err=1 in the cycle after the grant.
- Not defined: cpu_err and dma_err are tied to 0; addr[1:0] is ignored.

Test Plan:
- Reset: hold reset_n=0 mid-read (cpu_req=1, cpu_we=0) -> all outputs 0; no rvalid after release; FSM in PRI_CPU.
- CPU only: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> ram_addr=4, ram_we=1 on the write cycle; cpu_rvalid=1 one cycle after the read grant with cpu_rdata=0xDEADBEEF.
- Contention, MAX_WAIT=4: cpu_req and dma_req held high continuously -> cpu_gnt for 4 cycles, then dma_gnt=1 and dma_starved=1 in cycle 5; the pattern repeats every 5 cycles.
- Interleaved reads: CPU read 0x20 in cycle n, DMA read 0x24 in cycle n+1 -> cpu_rvalid in n+1 with mem[8]; dma_rvalid in n+2 with mem[9]; never both rvalid in the same cycle.
- Idle DMA: dma_req pulsed for 2 blocked cycles, then dropped -> wait_cnt returns to 0; no forced slot; FSM stays PRI_CPU.
- With DMEM_ALIGN_CHECK_EN: DMA write to 0x0000_0102 -> dma_gnt=1, ram_we=0, dma_err=1 next cycle; RAM content unchanged on read-back.
